// File: rtl/dvp_pkg.sv
// Shared timing defaults, one-hot state encoding and width helpers for the
// DVP frame generator.
package dvp_pkg;

    localparam int unsigned H_ACTIVE_DEF  = 320;
    localparam int unsigned H_BLANK_DEF   = 64;
    localparam int unsigned V_ACTIVE_DEF  = 240;
    localparam int unsigned VSYNC_LEN_DEF = 2;
    localparam int unsigned V_BACK_DEF    = 2;
    localparam int unsigned V_FRONT_DEF   = 2;
    localparam int unsigned PIX_DIV_DEF   = 16;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        VSYNC  = 5'b00010,
        VBACK  = 5'b00100,
        ACTIVE = 5'b01000,
        VFRONT = 5'b10000
    } dvp_state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : $clog2(n);
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/dvp_line_cnt.sv
// Pixel-slot divider and horizontal position counter; both rest at zero while
// the frame generator is idle.
module dvp_line_cnt
    import dvp_pkg::*;
#(
    parameter int unsigned PIX_DIV = PIX_DIV_DEF,
    parameter int unsigned H_TOTAL = H_ACTIVE_DEF + H_BLANK_DEF,
    localparam int unsigned DIV_W  = cnt_width(PIX_DIV),
    localparam int unsigned H_W    = cnt_width(H_TOTAL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    output logic [DIV_W-1:0] div_o,
    output logic [H_W-1:0]   h_o,
    output logic [H_W-1:0]   h_nxt_o,
    output logic             line_end_o,
    output logic             line_end_nxt_o
);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 32'd1);
    localparam logic [H_W-1:0]   H_LAST   = H_W'(H_TOTAL - 32'd1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [H_W-1:0]   h_q, h_d;

    // Next position: advance the divider, step h_cnt when the divider wraps.
    always_comb begin
        div_d = '0;
        h_d   = '0;
        if (run_i) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (h_q == H_LAST) begin
                    h_d = '0;
                end else begin
                    h_d = h_q + H_W'(1);
                end
            end else begin
                div_d = div_q + DIV_W'(1);
                h_d   = h_q;
            end
        end else begin
            div_d = '0;
            h_d   = '0;
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            h_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
        end
    end

    assign div_o          = div_q;
    assign h_o            = h_q;
    assign h_nxt_o        = h_d;
    assign line_end_o     = run_i && (div_q == DIV_LAST) && (h_q == H_LAST);
    assign line_end_nxt_o = (div_d == DIV_LAST) && (h_d == H_LAST);

endmodule

// File: rtl/dvp_frame_gen.sv
// DVP frame timing generator: paces an upstream RGB565 pixel stream into
// vsync/href/data_valid timing, substituting zero pixels on underflow.
module dvp_frame_gen
    import dvp_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
    parameter int unsigned H_BLANK   = H_BLANK_DEF,
    parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
    parameter int unsigned VSYNC_LEN = VSYNC_LEN_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned PIX_DIV   = PIX_DIV_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic        pix_valid_i,
    input  logic        pix_sof_i,
    input  logic [15:0] pix_data_i,
    output logic        pix_ready_o,
    output logic        vsync_o,
    output logic        href_o,
    output logic        data_valid_o,
    output logic [15:0] data_o,
    output logic        underflow_o,
    output logic        frame_done_o
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int unsigned DIV_W   = cnt_width(PIX_DIV);
    localparam int unsigned H_W     = cnt_width(H_TOTAL);
    localparam int unsigned V_W     = cnt_width(max4(VSYNC_LEN, V_BACK, V_ACTIVE, V_FRONT));

    localparam logic [H_W-1:0] H_ACT_L = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] VS_LAST = V_W'(VSYNC_LEN - 32'd1);
    localparam logic [V_W-1:0] VB_LAST = V_W'(V_BACK - 32'd1);
    localparam logic [V_W-1:0] VA_LAST = V_W'(V_ACTIVE - 32'd1);
    localparam logic [V_W-1:0] VF_LAST = V_W'(V_FRONT - 32'd1);

    dvp_state_e       state_q, state_d;
    logic [V_W-1:0]   v_q, v_d;
    logic [DIV_W-1:0] div_s;
    logic [H_W-1:0]   h_s, h_nxt_s;
    logic             line_end_s, line_end_nxt_s, seg_end_s, ready_act_s;
    logic             vsync_q, href_q, dv_q, uf_q, fd_q;
    logic [15:0]      data_q;

    dvp_line_cnt #(
        .PIX_DIV (PIX_DIV),
        .H_TOTAL (H_TOTAL)
    ) u_line_cnt (
        .clk            (clk),
        .rst_n          (rst_n),
        .run_i          (state_q != IDLE),
        .div_o          (div_s),
        .h_o            (h_s),
        .h_nxt_o        (h_nxt_s),
        .line_end_o     (line_end_s),
        .line_end_nxt_o (line_end_nxt_s)
    );

    // Last line of the current vertical segment.
    always_comb begin
        seg_end_s = 1'b0;
        case (state_q)
            VSYNC:   seg_end_s = line_end_s && (v_q == VS_LAST);
            VBACK:   seg_end_s = line_end_s && (v_q == VB_LAST);
            ACTIVE:  seg_end_s = line_end_s && (v_q == VA_LAST);
            VFRONT:  seg_end_s = line_end_s && (v_q == VF_LAST);
            default: seg_end_s = 1'b0;
        endcase
    end

    // Frame sequencing; enable_i is only sampled in IDLE and at frame end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_i) state_d = VSYNC;  else state_d = IDLE;
            VSYNC:   if (seg_end_s) state_d = VBACK;  else state_d = VSYNC;
            VBACK:   if (seg_end_s) state_d = ACTIVE; else state_d = VBACK;
            ACTIVE:  if (seg_end_s) state_d = VFRONT; else state_d = ACTIVE;
            VFRONT: begin
                if (seg_end_s) begin
                    if (enable_i) state_d = VSYNC; else state_d = IDLE;
                end else begin
                    state_d = VFRONT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line counter within the segment, restarting on every state change.
    always_comb begin
        v_d = v_q;
        if ((state_d != state_q) || (state_d == IDLE)) begin
            v_d = '0;
        end else if (line_end_s) begin
            v_d = v_q + V_W'(1);
        end else begin
            v_d = v_q;
        end
    end

    assign ready_act_s = (state_q == ACTIVE) && (h_s < H_ACT_L) && (div_s == '0);
    // In VBACK stale non-SOF pixels are drained so the SOF pixel lands first.
    assign pix_ready_o = ready_act_s ||
                         ((state_q == VBACK) && pix_valid_i && !pix_sof_i);

    // FSM and outputs, registered from next-state so they align with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            v_q     <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            dv_q    <= 1'b0;
            uf_q    <= 1'b0;
            fd_q    <= 1'b0;
            data_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            vsync_q <= (state_d == VSYNC);
            href_q  <= (state_d == ACTIVE) && (h_nxt_s < H_ACT_L);
            dv_q    <= ready_act_s;
            fd_q    <= (state_d == VFRONT) && line_end_nxt_s && (v_d == VF_LAST);
            if (ready_act_s) begin
                data_q <= pix_valid_i ? pix_data_i : 16'h0000;
            end else begin
                data_q <= data_q;
            end
            if ((state_d == VSYNC) && (state_q != VSYNC)) begin
                uf_q <= 1'b0;
            end else if (ready_act_s && !pix_valid_i) begin
                uf_q <= 1'b1;
            end else begin
                uf_q <= uf_q;
            end
        end
    end

    assign vsync_o      = vsync_q;
    assign href_o       = href_q;
    assign data_valid_o = dv_q;
    assign data_o       = data_q;
    assign underflow_o  = uf_q;
    assign frame_done_o = fd_q;

endmodule

// File: tb/tb_dvp_frame_gen.sv
// Directed bench for dvp_frame_gen with a small geometry: 6 slots x 2 clocks
// per line, 1+1+3+1 lines per frame (72 clocks).
module tb_dvp_frame_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable_i;
    logic        pix_valid_i;
    logic        pix_sof_i;
    logic [15:0] pix_data_i;
    logic        pix_ready_o, vsync_o, href_o, data_valid_o, underflow_o, frame_done_o;
    logic [15:0] data_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dvp_frame_gen #(
        .H_ACTIVE (4), .H_BLANK (2), .V_ACTIVE (3),
        .VSYNC_LEN(1), .V_BACK  (1), .V_FRONT  (1), .PIX_DIV (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .pix_valid_i  (pix_valid_i),
        .pix_sof_i    (pix_sof_i),
        .pix_data_i   (pix_data_i),
        .pix_ready_o  (pix_ready_o),
        .vsync_o      (vsync_o),
        .href_o       (href_o),
        .data_valid_o (data_valid_o),
        .data_o       (data_o),
        .underflow_o  (underflow_o),
        .frame_done_o (frame_done_o)
    );

    // Scenario records: stimulus knobs plus hand-derived end expectations.
    typedef struct {
        string name;
        int    drop_idx;     // pixel index sent with valid low, -1 none
        int    n_stale;      // non-SOF pixels queued ahead of the frame
        int    en_drop_t;    // cycle after VSYNC entry where enable falls, -1 none
        bit    exp_restart;  // vsync expected again at cycle 72
        int    exp_heads;    // source items consumed by end of run
    } scen_t;

    scen_t scen[4];

    task automatic check(input string tag, input int t, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d got=%h expected=%h", tag, t, act, exp);
        end
    endtask

    // Hold reset for two clocks and check the reset state; returns #1 after a negedge.
    task automatic do_reset(input string tag);
        rst_n       = 1'b0;
        enable_i    = 1'b0;
        pix_valid_i = 1'b0;
        pix_sof_i   = 1'b0;
        pix_data_i  = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        #1;
        check({tag, " reset_ctl"}, -1,
              {26'd0, vsync_o, href_o, data_valid_o, frame_done_o, underflow_o, pix_ready_o},
              32'd0);
        check({tag, " reset_data"}, -1, {16'd0, data_o}, 32'd0);
    endtask

    task automatic run_scen(input int s);
        scen_t       sc;
        int          head, total, p, line, pos, h, dv_t;
        logic        act_l, e_vs, e_href, e_dv, e_fd, e_uf, e_rdy;
        logic [15:0] e_data;
        sc    = scen[s];
        total = sc.n_stale + 12;
        head  = 0;
        dv_t  = (sc.drop_idx >= 0) ?
                24 + 12 * (sc.drop_idx / 4) + 2 * (sc.drop_idx % 4) + 1 : 1000;
        do_reset(sc.name);
        enable_i = 1'b1;
        rst_n    = 1'b1;
        for (int t = 0; t < 84; t++) begin
            @(negedge clk);
            if (t == sc.en_drop_t) enable_i = 1'b0;
            if (head >= total) begin
                pix_valid_i = 1'b0; pix_sof_i = 1'b0; pix_data_i = 16'h0000;
            end else if (head < sc.n_stale) begin
                pix_valid_i = 1'b1; pix_sof_i = 1'b0; pix_data_i = 16'hEE00 + 16'(head);
            end else begin
                p           = head - sc.n_stale;
                pix_sof_i   = (p == 0);
                pix_data_i  = 16'(p + 1);
                pix_valid_i = (p != sc.drop_idx);
            end
            #1;
            line  = t / 12;
            pos   = t % 12;
            h     = pos / 2;
            act_l = (t < 72) && (line >= 2) && (line <= 4);
            e_vs   = (t < 72) ? (line == 0) : sc.exp_restart;
            e_href = act_l && (h < 4);
            e_dv   = act_l && (h < 4) && (pos % 2 == 1);
            e_fd   = (t == 71);
            e_uf   = (t >= dv_t) && (t < 72);
            if (act_l)
                e_rdy = (h < 4) && (pos % 2 == 0);
            else if ((t < 72) && (line == 1))
                e_rdy = pix_valid_i && !pix_sof_i;
            else
                e_rdy = 1'b0;
            check({sc.name, " timing"}, t,
                  {26'd0, vsync_o, href_o, data_valid_o, frame_done_o, underflow_o, pix_ready_o},
                  {26'd0, e_vs, e_href, e_dv, e_fd, e_uf, e_rdy});
            if (act_l && (pos >= 1) && (pos <= 8)) begin
                p      = (line - 2) * 4 + (pos - 1) / 2;
                e_data = (p == sc.drop_idx) ? 16'h0000 : 16'(p + 1);
                check({sc.name, " data"}, t, {16'd0, data_o}, {16'd0, e_data});
            end
            if (pix_ready_o) begin
                if (pix_valid_i)
                    head++;
                else if ((sc.drop_idx >= 0) && (head < total) &&
                         (head - sc.n_stale == sc.drop_idx))
                    head++;
            end
        end
        check({sc.name, " consumed"}, 84, head, sc.exp_heads);
    endtask

    // Reset mid-ACTIVE: async clear of all outputs, then vsync on the first clock.
    task automatic run_reset_abort();
        do_reset("abort");
        enable_i   = 1'b1;
        pix_sof_i  = 1'b0;
        pix_data_i = 16'hABCD;
        rst_n      = 1'b1;
        for (int t = 0; t <= 30; t++) begin
            @(negedge clk);
            pix_valid_i = (t != 24);
            #1;
        end
        check("abort pre_href", 30, {31'd0, href_o}, 32'd1);
        check("abort pre_uf", 30, {31'd0, underflow_o}, 32'd1);
        check("abort pre_data", 30, {16'd0, data_o}, {16'd0, 16'hABCD});
        rst_n = 1'b0;
        #1;
        check("abort async_ctl", 30,
              {26'd0, vsync_o, href_o, data_valid_o, frame_done_o, underflow_o, pix_ready_o},
              32'd0);
        check("abort async_data", 30, {16'd0, data_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort vsync_before_clk", 0, {31'd0, vsync_o}, 32'd0);
        @(posedge clk);
        #1;
        check("abort vsync_first_clk", 1, {31'd0, vsync_o}, 32'd1);
        check("abort href_first_clk", 1, {31'd0, href_o}, 32'd0);
    endtask

    initial begin
        scen[0] = '{name: "nominal",     drop_idx: -1, n_stale: 0, en_drop_t: -1,
                    exp_restart: 1'b1, exp_heads: 12};
        scen[1] = '{name: "underflow",   drop_idx: 5,  n_stale: 0, en_drop_t: -1,
                    exp_restart: 1'b1, exp_heads: 12};
        scen[2] = '{name: "vback_stale", drop_idx: -1, n_stale: 3, en_drop_t: -1,
                    exp_restart: 1'b1, exp_heads: 15};
        scen[3] = '{name: "enable_drop", drop_idx: -1, n_stale: 0, en_drop_t: 42,
                    exp_restart: 1'b0, exp_heads: 12};
        for (int s = 0; s < 4; s++) run_scen(s);
        run_reset_abort();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dvp_frame_gen.md
DVP_FRAME_GEN -- requirements
Module: dvp_frame_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, 320, active pixels per line.
REQ-002 SHALL have parameter H_BLANK, 64, blanking pixel slots per line.
REQ-003 SHALL have parameter V_ACTIVE, 240, active lines per frame.
REQ-004 SHALL have parameters VSYNC_LEN / V_BACK / V_FRONT, 2 / 2 / 2, lines of vsync, back porch, and front porch.
REQ-005 SHALL have parameter PIX_DIV, 16, clocks per pixel slot; this matches the downstream DVP serializer rate.
REQ-006 SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-007 clk  in  1  system clock, 25 MHz.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 enable_i  in  1  run frames while high.
REQ-010 pix_valid_i  in  1  upstream pixel available.
REQ-011 pix_sof_i  in  1  marks the first pixel of a frame; qualified by pix_valid_i.
REQ-012 pix_data_i  in  16  RGB565 pixel.
REQ-013 pix_ready_o  out  1  pixel accepted this cycle when high together with pix_valid_i.
REQ-014 vsync_o / href_o / data_valid_o  out  1 each  timing for the downstream DVP transmitter.
REQ-015 data_o  out  16  RGB565 pixel to the transmitter.
REQ-016 underflow_o  out  1  sticky flag for a missing pixel in the current frame.
REQ-017 frame_done_o  out  1  one-clock pulse at the end of each frame.

Function
REQ-018 SHALL use states IDLE, VSYNC, VBACK, ACTIVE, VFRONT; line position SHALL come from counters div_cnt (0..PIX_DIV-1), h_cnt (0..H_ACTIVE+H_BLANK-1) and v_cnt.
REQ-019 Line period SHALL be (H_ACTIVE+H_BLANK)*PIX_DIV clocks in all non-IDLE states; h_cnt and v_cnt SHALL wrap at their maximums.
REQ-020 IDLE->VSYNC on enable_i=1; VSYNC->VBACK after VSYNC_LEN lines; VBACK->ACTIVE after V_BACK lines; ACTIVE->VFRONT after V_ACTIVE lines.
REQ-021 VFRONT->VSYNC after V_FRONT lines if enable_i=1, otherwise VFRONT->IDLE; an enable_i drop mid-frame SHALL NOT truncate the frame.
REQ-022 vsync_o SHALL be high exactly for the VSYNC state duration.
REQ-023 In ACTIVE, href_o SHALL be high while h_cnt<H_ACTIVE, i.e. H_ACTIVE*PIX_DIV clocks per line.
REQ-024 pix_ready_o SHALL be combinational: high in ACTIVE when h_cnt<H_ACTIVE and div_cnt==0.
REQ-025 In VBACK, pix_ready_o SHALL be high whenever pix_valid_i=1 and pix_sof_i=0, discarding stale pixels to resynchronise; an SOF pixel SHALL be held in VBACK and not consumed.
REQ-026 data_valid_o SHALL pulse for one clock, registered one cycle after each pix_ready_o slot in ACTIVE, aligned with href_o.
REQ-027 data_o SHALL load pix_data_i on that slot and hold for PIX_DIV clocks; output latency from the handshake SHALL be 1 clock.
REQ-028 Underflow: if pix_valid_i=0 at a ready slot, data_o SHALL be 16'h0000, data_valid_o SHALL still pulse, and underflow_o SHALL be set.
REQ-029 underflow_o SHALL clear on VSYNC entry.
REQ-030 A pix_sof_i=1 accepted at any slot other than the first of a frame SHALL be consumed as normal data, with no realignment.
REQ-031 frame_done_o SHALL pulse on the last clock of VFRONT.

Reset
REQ-032 On rst_n low, SHALL enter IDLE with all counters 0 and vsync_o, href_o, data_valid_o, frame_done_o, underflow_o = 0 and data_o = 16'h0000.
REQ-033 pix_ready_o SHALL be 0 during reset.
REQ-034 Reset asserted mid-frame SHALL abort immediately; the next frame SHALL start from VSYNC.

Structure
REQ-035 Timing defaults and state encodings SHALL live in the shared package dvp_pkg; state encoding SHALL be one-hot.
REQ-036 SHALL be a single module with no sub-modules; a single counter sub-module dvp_line_cnt (div_cnt/h_cnt) is permitted.

Verification (H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, VSYNC_LEN=V_BACK=V_FRONT=1, PIX_DIV=2)
REQ-037 Continuous valid source, pixels 0x0001..0x000C, SOF on first -> vsync_o high for 12 clocks, each line has href_o high for 8 clocks, data_valid_o pulses every 2 clocks with data 0x0001..0x000C, and frame_done_o fires 72 clocks after VSYNC entry.
REQ-038 pix_valid_i dropped for the 6th pixel -> data_o=0x0000 on that slot, underflow_o=1 until the next VSYNC, and line timing is unchanged.
REQ-039 Three non-SOF pixels presented during VBACK -> all three discarded, and the first ACTIVE pixel is the SOF pixel.
REQ-040 enable_i deasserted in the middle of line 2 -> the frame completes, frame_done_o pulses, the block goes to IDLE, and no further vsync_o.
REQ-041 rst_n pulsed low during ACTIVE -> all outputs 0 asynchronously; after release with enable_i=1, vsync_o rises on the first clock.
